// File: rtl/ddr3_iod_rx_delay_train.sv
// Read-capture delay-line trainer for one DDR3 IOD lane: sweeps taps against a fixed
// training pattern, keeps the first wide-enough passing window and parks at its centre.
module ddr3_iod_rx_delay_train #(
  parameter logic [3:0] PATTERN    = 4'b0101,
  parameter int         MAX_TAPS   = 128,
  parameter int         TAP_W      = 8,
  parameter int         SETTLE_CYC = 4,
  parameter int         SAMPLE_CYC = 8,
  parameter int         MIN_WIN    = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             START,
  input  logic [3:0]       RX_DATA,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] TAP_START,
  output logic [TAP_W-1:0] TAP_END,
  output logic [TAP_W-1:0] TAP_CENTER,
  output logic [2:0]       STATE_DBG
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_STEP, S_CENTER, S_DONE, S_FAIL
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS - 1);
  localparam logic [TAP_W:0]   MIN_WIDTH   = (TAP_W+1)'(MIN_WIN);

  state_t           state, state_n;
  logic [TAP_W-1:0] cur_tap, cur_tap_n;
  logic [TAP_W-1:0] win_start, win_start_n;
  logic [TAP_W-1:0] win_end, win_end_n;
  logic [TAP_W-1:0] move_cnt, move_cnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             in_win, in_win_n;
  logic             centering, centering_n;
  logic             dir_q, dir_n;
  logic             busy_n, done_n, fail_n;
  logic [TAP_W-1:0] tap_start_n, tap_end_n, tap_center_n;
  logic             load_pulse, move_pulse;

  // Window-closing arithmetic: a failing tap closes at cur_tap-1, a limit closes at cur_tap.
  logic [TAP_W-1:0] close_end;
  logic [TAP_W:0]   span, mid_sum;
  logic             win_ok, at_limit;

  always_comb begin
    close_end = (state == S_CHECK) ? cur_tap - TAP_W'(1) : cur_tap;
    span      = {1'b0, close_end} - {1'b0, win_start} + (TAP_W+1)'(1);
    mid_sum   = {1'b0, win_start} + {1'b0, close_end};
    win_ok    = in_win && (span >= MIN_WIDTH);
    at_limit  = (cur_tap == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE;
  end

  always_comb begin
    logic do_accept;
    logic do_fail;
    state_n      = state;
    cur_tap_n    = cur_tap;
    win_start_n  = win_start;
    win_end_n    = win_end;
    move_cnt_n   = move_cnt;
    cnt_n        = cnt;
    in_win_n     = in_win;
    centering_n  = centering;
    dir_n        = dir_q;
    busy_n       = BUSY;
    done_n       = DONE;
    fail_n       = FAIL;
    tap_start_n  = TAP_START;
    tap_end_n    = TAP_END;
    tap_center_n = TAP_CENTER;
    load_pulse   = 1'b0;
    move_pulse   = 1'b0;
    do_accept    = 1'b0;
    do_fail      = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (START) begin
          busy_n       = 1'b1;
          done_n       = 1'b0;
          fail_n       = 1'b0;
          tap_start_n  = '0;
          tap_end_n    = '0;
          tap_center_n = '0;
          state_n      = S_LOAD;
        end
      end
      S_LOAD: begin
        load_pulse  = 1'b1;
        cur_tap_n   = '0;
        in_win_n    = 1'b0;
        centering_n = 1'b0;
        cnt_n       = '0;
        state_n     = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = centering ? S_CENTER : S_CHECK;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (RX_DATA != PATTERN) begin
          cnt_n = '0;
          if (win_ok) begin
            do_accept = 1'b1;
          end else begin
            in_win_n = 1'b0;
            state_n  = S_STEP;
          end
        end else if (cnt == SAMPLE_LAST) begin
          cnt_n = '0;
          if (!in_win) begin
            win_start_n = cur_tap;
            in_win_n    = 1'b1;
          end
          state_n = S_STEP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_STEP: begin
        if (at_limit) begin
          if (win_ok) do_accept = 1'b1;
          else        do_fail   = 1'b1;
        end else begin
          move_pulse = 1'b1;
          dir_n      = 1'b1;
          cur_tap_n  = cur_tap + TAP_W'(1);
          state_n    = S_SETTLE;
        end
      end
      S_CENTER: begin
        if (move_cnt == '0) begin
          tap_start_n = win_start;
          tap_end_n   = win_end;
          done_n      = 1'b1;
          busy_n      = 1'b0;
          state_n     = S_DONE;
        end else begin
          move_pulse = 1'b1;
          dir_n      = 1'b0;
          move_cnt_n = move_cnt - TAP_W'(1);
          cur_tap_n  = cur_tap - TAP_W'(1);
          state_n    = S_SETTLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // The centre is at or below cur_tap, so the move count never underflows.
    if (do_accept) begin
      win_end_n    = close_end;
      tap_center_n = mid_sum[TAP_W:1];
      move_cnt_n   = cur_tap - mid_sum[TAP_W:1];
      centering_n  = 1'b1;
      state_n      = S_CENTER;
    end
    if (do_fail) begin
      fail_n       = 1'b1;
      busy_n       = 1'b0;
      tap_start_n  = '0;
      tap_end_n    = '0;
      tap_center_n = '0;
      state_n      = S_FAIL;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state      <= S_IDLE;
      cur_tap    <= '0;
      win_start  <= '0;
      win_end    <= '0;
      move_cnt   <= '0;
      cnt        <= '0;
      in_win     <= 1'b0;
      centering  <= 1'b0;
      dir_q      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      FAIL       <= 1'b0;
      TAP_START  <= '0;
      TAP_END    <= '0;
      TAP_CENTER <= '0;
    end else begin
      state      <= state_n;
      cur_tap    <= cur_tap_n;
      win_start  <= win_start_n;
      win_end    <= win_end_n;
      move_cnt   <= move_cnt_n;
      cnt        <= cnt_n;
      in_win     <= in_win_n;
      centering  <= centering_n;
      dir_q      <= dir_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
      FAIL       <= fail_n;
      TAP_START  <= tap_start_n;
      TAP_END    <= tap_end_n;
      TAP_CENTER <= tap_center_n;
    end
  end

  // Direction is presented together with MOVE and then held until the next pulse.
  assign DELAY_LINE_LOAD      = load_pulse;
  assign DELAY_LINE_MOVE      = move_pulse;
  assign DELAY_LINE_DIRECTION = dir_n;
  assign STATE_DBG            = state;

endmodule
